// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared sizes and types for the 32x8 scratch RAM
package ram_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/ram_32x8.sv
// rtl/ram_32x8.sv - single-port 32x8 RAM with registered read and async clear
module ram_32x8
   import ram_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  word_t data_in,
   input  addr_t addr,
   input  logic  wr_rd,
   output word_t data_out
);

   word_t mem [DEPTH];

   // Whole array clears on reset so never-written words read back as zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         data_out <= '0;
      end else if (wr_rd) begin
         mem[addr] <= data_in;
      end else begin
         data_out <= mem[addr];
      end
   end

endmodule

// File: tb/tb_ram_32x8.sv
// tb/tb_ram_32x8.sv - self-checking bench for ram_32x8 against an array model
module tb_ram_32x8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic [4:0] addr;
   logic       wr_rd;
   logic [7:0] data_out;

   logic [7:0] model_mem [32];
   logic [7:0] model_out;
   int         n_checks = 0;
   int         n_fail   = 0;

   ram_32x8 dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .addr     (addr),
      .wr_rd    (wr_rd),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
      model_out = 8'h00;
   endtask

   task automatic do_op(input logic w, input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_rd   = w;
      addr    = a;
      data_in = d;
      @(posedge clk);
      #1;
      if (w) model_mem[a] = d;
      else   model_out    = model_mem[a];
   endtask

   initial begin
      logic [7:0] r;
      rst     = 1'b0;
      wr_rd   = 1'b0;
      addr    = '0;
      data_in = '0;
      model_reset();
      #1;
      check("reset_state", data_out, 8'h00);

      // Preload, make data_out nonzero, then hold reset for two cycles
      @(negedge clk); rst = 1'b1;
      do_op(1'b1, 5'd0,  8'h11);
      do_op(1'b1, 5'd15, 8'h22);
      do_op(1'b1, 5'd31, 8'h33);
      do_op(1'b0, 5'd15, 8'h00);
      check("preload_rd15", data_out, model_out);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("reset_hold_out", data_out, 8'h00);
      @(negedge clk); rst = 1'b1;
      do_op(1'b0, 5'd0,  8'h00); check("post_rst_rd0",  data_out, 8'h00);
      do_op(1'b0, 5'd15, 8'h00); check("post_rst_rd15", data_out, 8'h00);
      do_op(1'b0, 5'd31, 8'h00); check("post_rst_rd31", data_out, 8'h00);

      // Write sweep with random data; data_out must hold through writes
      do_op(1'b0, 5'd0, 8'h00);
      for (int i = 0; i < 32; i++) begin
         r = 8'($urandom_range(100, 10));
         do_op(1'b1, 5'(i), r);
         check($sformatf("wr_hold_%0d", i), data_out, model_out);
      end
      for (int i = 0; i < 32; i++) begin
         do_op(1'b0, 5'(i), 8'($urandom));
         check($sformatf("sweep_rd_%0d", i), data_out, model_out);
      end

      // Boundary addresses
      do_op(1'b1, 5'd31, 8'hFF);
      do_op(1'b1, 5'd0,  8'h01);
      do_op(1'b0, 5'd31, 8'h00); check("bound_rd31", data_out, 8'hFF);
      do_op(1'b0, 5'd0,  8'h00); check("bound_rd0",  data_out, 8'h01);
      do_op(1'b0, 5'd1,  8'h00); check("bound_rd1",  data_out, model_out);
      do_op(1'b0, 5'd30, 8'h00); check("bound_rd30", data_out, model_out);

      // Overwrite, then read on the very next edge
      do_op(1'b1, 5'd7, 8'h55);
      do_op(1'b1, 5'd7, 8'hAA);
      do_op(1'b0, 5'd7, 8'h00); check("overwrite_rd7", data_out, 8'hAA);

      // Asynchronous reset between edges
      do_op(1'b1, 5'd3, 8'h42);
      do_op(1'b0, 5'd3, 8'h00); check("pre_async_rd3", data_out, 8'h42);
      #1 rst = 1'b0;
      #2;
      model_reset();
      check("async_rst_out", data_out, 8'h00);
      @(negedge clk); rst = 1'b1;
      do_op(1'b0, 5'd3, 8'h00); check("post_async_rd3", data_out, 8'h00);

      // Glitch immunity: inputs wiggle between edges during reads
      do_op(1'b1, 5'd9,  8'h9C);
      do_op(1'b1, 5'd10, 8'hA5);
      do_op(1'b1, 5'd12, 8'hC3);
      @(negedge clk);
      wr_rd = 1'b0; addr = 5'd10; data_in = 8'h77;
      #1 addr = 5'd12; data_in = 8'h13;
      #1 addr = 5'd9;
      @(posedge clk);
      #1;
      model_out = model_mem[9];
      check("glitch_sampled", data_out, 8'h9C);
      #1 addr = 5'd10; data_in = 8'hEE;
      #1 addr = 5'd12;
      check("glitch_hold", data_out, model_out);
      do_op(1'b0, 5'd10, 8'h00); check("glitch_rd10", data_out, model_mem[10]);
      do_op(1'b0, 5'd12, 8'h00); check("glitch_rd12", data_out, model_mem[12]);
      do_op(1'b0, 5'd9,  8'h00); check("glitch_rd9",  data_out, 8'h9C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
